// File: rtl/lbdr_input_buffer.sv
// Per-port input flit FIFO feeding the LBDR stage, with show-ahead head-flit decode.
// Optional packet-framing checker is built when LBDR_BUF_PKT_CHECK_EN is defined.
module lbdr_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    flit_in,
  output logic                     full,
  input  logic                     rd_en,
  output logic                     empty,
  output logic [DATA_WIDTH-1:0]    flit_out,
  output logic [2:0]               flit_id,
  output logic [3:0]               dst_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf_err;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_frame_err;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign w_wr_acc = wr_en && !full;
  assign w_rd_acc = rd_en && !empty;

  assign flit_out = empty ? '0 : r_mem[r_rd_ptr];
  assign flit_id  = flit_out[DATA_WIDTH-1 -: 3];
  assign dst_addr = flit_out[3:0];

  // NOTE: storage carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= flit_in;
  end

  // NOTE: reset is synchronous (sampled on the edge) and state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A write into a full FIFO is dropped even if a pop frees a slot this edge.
      if (wr_en && full) r_ovf_err <= 1'b1;
    end
  end

`ifdef LBDR_BUF_PKT_CHECK_EN
  localparam logic [2:0] ID_HEADER  = 3'b001;
  localparam logic [2:0] ID_PAYLOAD = 3'b010;
  localparam logic [2:0] ID_TAIL    = 3'b100;

  typedef enum logic [0:0] {ST_IDLE, ST_BODY} state_t;

  state_t r_state;
  logic   r_frame_err;

  // Framing is judged on the flit actually leaving the FIFO, so it only advances on a pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_frame_err <= 1'b0;
    end else if (w_rd_acc) begin
      case (r_state)
        ST_IDLE: begin
          if (flit_id == ID_HEADER) r_state <= ST_BODY;
          else                      r_frame_err <= 1'b1;
        end
        ST_BODY: begin
          if (flit_id == ID_TAIL)          r_state <= ST_IDLE;
          else if (flit_id != ID_PAYLOAD)  r_frame_err <= 1'b1;
        end
      endcase
    end
  end

  assign w_frame_err = r_frame_err;
`else
  assign w_frame_err = 1'b0;
`endif

  assign err = r_ovf_err | w_frame_err;

endmodule

// File: tb/tb_lbdr_input_buffer.sv
// Bench for lbdr_input_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_lbdr_input_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

`ifdef LBDR_BUF_PKT_CHECK_EN
  localparam logic EXP_LONE_ERR = 1'b1;
`else
  localparam logic EXP_LONE_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] flit_in;
  logic          full;
  logic          rd_en;
  logic          empty;
  logic [DW-1:0] flit_out;
  logic [2:0]    flit_id;
  logic [3:0]    dst_addr;
  logic [2:0]    count;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  lbdr_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .flit_in  (flit_in),
    .full     (full),
    .rd_en    (rd_en),
    .empty    (empty),
    .flit_out (flit_out),
    .flit_id  (flit_id),
    .dst_addr (dst_addr),
    .count    (count),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of flits, a sticky error bit and an in-packet flag.
  logic [DW-1:0] m_q[$];
  logic          m_err;
  logic          m_in_pkt;
  logic          m_valid = 1'b0;

  always @(posedge clk) begin
    logic [DW-1:0] f;
    logic [2:0]    id;
    if (!rst) begin
      m_q.delete();
      m_err    = 1'b0;
      m_in_pkt = 1'b0;
    end else begin
      logic do_wr;
      do_wr = wr_en && (m_q.size() < DEPTH);
      if (wr_en && m_q.size() == DEPTH) m_err = 1'b1;
      if (rd_en && m_q.size() > 0) begin
        f  = m_q.pop_front();
        id = f[DW-1:DW-3];
`ifdef LBDR_BUF_PKT_CHECK_EN
        if (!m_in_pkt) begin
          if (id == 3'b001) m_in_pkt = 1'b1;
          else              m_err = 1'b1;
        end else begin
          if (id == 3'b100)      m_in_pkt = 1'b0;
          else if (id != 3'b010) m_err = 1'b1;
        end
`endif
      end
      if (do_wr) m_q.push_back(flit_in);
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [DW-1:0] head;
      head = (m_q.size() == 0) ? '0 : m_q[0];
      check("m_empty",    empty,    (m_q.size() == 0));
      check("m_full",     full,     (m_q.size() == DEPTH));
      check("m_count",    count,    m_q.size());
      check("m_flit_out", flit_out, head);
      check("m_flit_id",  flit_id,  head[DW-1:DW-3]);
      check("m_dst_addr", dst_addr, head[3:0]);
      check("m_err",      err,      m_err);
    end
  end

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    wr_en   = w;
    flit_in = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flit_in = '0;

    // Reset then idle
    do_reset();
    step(1'b0, '0, 1'b0);
    check("rst_empty",    empty,    1);
    check("rst_full",     full,     0);
    check("rst_count",    count,    0);
    check("rst_err",      err,      0);
    check("rst_flit_out", flit_out, 0);
    check("rst_flit_id",  flit_id,  0);
    check("rst_dst_addr", dst_addr, 0);

    // Single write, one-cycle latency to the head
    step(1'b1, 32'h2000_000A, 1'b0);
    check("single_empty",   empty,    0);
    check("single_flit_id", flit_id,  3'b001);
    check("single_dst",     dst_addr, 4'hA);
    check("single_count",   count,    1);
    step(1'b0, '0, 1'b1);
    check("single_pop_empty", empty, 1);
    check("single_pop_count", count, 0);

    // Fill and overflow with a concurrent pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h4000_0010 + i, 1'b0);
    check("fill_full",  full,  1);
    check("fill_count", count, 4);
    check("ovf_head",   flit_out, 32'h4000_0010);
    step(1'b1, 32'h4000_00FF, 1'b1);
    check("ovf_count", count, 3);
    check("ovf_err",   err,   1);
    for (int i = 1; i < DEPTH; i++) begin
      check("ovf_order", flit_out, 32'h4000_0010 + i);
      step(1'b0, '0, 1'b1);
    end
    check("ovf_drained", empty, 1);

    // Well-formed packet, then a lone payload
    do_reset();
    step(1'b1, 32'h2000_0005, 1'b0);
    step(1'b1, 32'h4000_0001, 1'b0);
    step(1'b1, 32'h4000_0002, 1'b0);
    step(1'b1, 32'h8000_0003, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    check("pkt_err", err, 0);
    check("pkt_empty", empty, 1);
    step(1'b1, 32'h4000_0009, 1'b0);
    step(1'b0, '0, 1'b1);
    check("lone_payload_err", err, EXP_LONE_ERR);

    // Simultaneous read/write at count 2 across pointer wrap
    do_reset();
    step(1'b1, 32'h4000_0100, 1'b0);
    step(1'b1, 32'h4000_0101, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("rw_head", flit_out, 32'h4000_0100 + i);
      step(1'b1, 32'h4000_0102 + i, 1'b1);
      check("rw_count", count, 2);
    end
    for (int i = 10; i < 12; i++) begin
      check("rw_tail_order", flit_out, 32'h4000_0100 + i);
      step(1'b0, '0, 1'b1);
    end
    check("rw_empty", empty, 1);

    // Reset mid-packet, with reset taking priority over traffic
    do_reset();
    step(1'b1, 32'h2000_0001, 1'b0);
    step(1'b1, 32'h4000_0002, 1'b0);
    step(1'b1, 32'h4000_0003, 1'b0);
    step(1'b1, 32'h8000_0004, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    check("mid_count", count, 2);
    rst = 1'b0;
    step(1'b1, 32'h4000_0077, 1'b1);
    rst = 1'b1;
    check("mid_rst_empty", empty, 1);
    check("mid_rst_count", count, 0);
    check("mid_rst_err",   err,   0);
    step(1'b1, 32'h2000_0007, 1'b0);
    check("new_hdr_dst", dst_addr, 4'h7);
    step(1'b0, '0, 1'b1);
    check("new_hdr_err", err, 0);
    step(1'b1, 32'h8000_0008, 1'b0);
    step(1'b0, '0, 1'b1);
    check("new_tail_err", err, 0);
    step(1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
